// File: rtl/bn_nibble_subtractor.sv
// Multi-cycle N-bit subtractor: Z = X - Y computed as X + ~Y + 1,
// one nibble per clock through a single 4-bit carry-lookahead block.

// 4-bit carry-lookahead adder slice with signed overflow flag.
module b4_cla_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out,
    output logic       ovf
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_in);
        s     = p ^ c[3:0];
        c_out = c[4];
        ovf   = (a[3] == b[3]) && (s[3] != a[3]);
    end

endmodule

module bn_nibble_subtractor #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Z,
    output logic         B_out,
    output logic         overflow
);

    localparam int NIB = N / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    // Reject widths that cannot be split into at least two whole nibbles.
    if ((N % 4 != 0) || (N < 8)) begin : g_bad_n
        $error("bn_nibble_subtractor: N must be a multiple of 4 and >= 8");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  z_q, z_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          bout_q, bout_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;

    logic [CW+1:0] nib_base;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    nib_s;
    logic          nib_c_out;
    logic          nib_ovf;

    // Select the current nibble of each operand register.
    always_comb begin
        nib_base = {cnt_q, 2'b00};
        nib_a    = a_q[nib_base +: 4];
        nib_b    = b_q[nib_base +: 4];
    end

    b4_cla_block u_cla (
        .a     (nib_a),
        .b     (nib_b),
        .c_in  (carry_q),
        .s     (nib_s),
        .c_out (nib_c_out),
        .ovf   (nib_ovf)
    );

    // Next-state and datapath update for the IDLE/RUN controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = X;
                    b_d     = ~Y;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    z_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                z_d[nib_base +: 4] = nib_s;
                carry_d = nib_c_out;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bout_d  = ~nib_c_out;
                    ovf_d   = nib_ovf;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign Z        = z_q;
    assign B_out    = bout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bn_nibble_subtractor.sv
// Directed self-checking bench for bn_nibble_subtractor (N=16).
// Hand-computed vectors cross-checked against a reference model.
module tb_bn_nibble_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] X;
    logic [15:0] Y;
    logic        busy;
    logic        done;
    logic [15:0] Z;
    logic        B_out;
    logic        overflow;

    int n_checks;
    int n_fail;

    bn_nibble_subtractor #(.N(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .X        (X),
        .Y        (Y),
        .busy     (busy),
        .done     (done),
        .Z        (Z),
        .B_out    (B_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] ref_sub(input logic [15:0] x,
                                            input logic [15:0] y);
        logic [15:0] d;
        logic        b;
        logic        v;
        d = x - y;
        b = (x < y);
        v = (x[15] != y[15]) && (d[15] != x[15]);
        return {b, v, d};
    endfunction

    // Launch one op; lat = edge index of done (0 on timeout), bcnt = busy cycles.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          output int lat, output int bcnt);
        @(negedge clk);
        X = x;
        Y = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        X = '0;
        Y = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, B_out, overflow, Z} !== 20'h0) begin
            $display("FAIL reset_state got=%h exp=0",
                     {busy, done, B_out, overflow, Z});
            n_fail++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        logic [15:0] xs [5];
        logic [15:0] ys [5];
        logic [17:0] hx [5];
        logic [17:0] m;
        int lat;
        int bcnt;
        xs = '{16'h0005, 16'h0003, 16'h8000, 16'h7FFF, 16'h1234};
        ys = '{16'h0003, 16'h0005, 16'h0001, 16'hFFFF, 16'h0000};
        hx = '{{2'b00, 16'h0002}, {2'b10, 16'hFFFE}, {2'b01, 16'h7FFF},
               {2'b11, 16'h8000}, {2'b00, 16'h1234}};
        for (int k = 0; k < 5; k++) begin
            run_op(xs[k], ys[k], lat, bcnt);
            m = ref_sub(xs[k], ys[k]);
            n_checks++;
            if (lat !== 4 || bcnt !== 4) begin
                $display("FAIL latency[%0d] got lat=%0d busy=%0d exp 4/4",
                         k, lat, bcnt);
                n_fail++;
            end
            n_checks++;
            if ({B_out, overflow, Z} !== hx[k]) begin
                $display("FAIL result[%0d] got=%h exp=%h",
                         k, {B_out, overflow, Z}, hx[k]);
                n_fail++;
            end
            n_checks++;
            if ({B_out, overflow, Z} !== m) begin
                $display("FAIL model[%0d] got=%h exp=%h",
                         k, {B_out, overflow, Z}, m);
                n_fail++;
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || Z !== hx[k][15:0]) begin
                $display("FAIL hold[%0d] got done=%b z=%h exp 0/%h",
                         k, done, Z, hx[k][15:0]);
                n_fail++;
            end
        end
    endtask

    task automatic test_ignored_start;
        int dones;
        @(negedge clk);
        X = 16'h1234;
        Y = 16'h1234;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        X = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                n_checks++;
                if ({B_out, overflow, Z} !== 18'h0) begin
                    $display("FAIL ignored_start_z got=%h exp=0",
                             {B_out, overflow, Z});
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (dones !== 1 || busy !== 1'b0) begin
            $display("FAIL ignored_start_pulses got=%0d busy=%b exp 1/0",
                     dones, busy);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int bcnt;
        run_op(16'h0010, 16'h0001, lat, bcnt);
        n_checks++;
        if (lat !== 4 || Z !== 16'h000F) begin
            $display("FAIL b2b_first got lat=%0d z=%h exp 4/000f", lat, Z);
            n_fail++;
        end
        X = 16'h0100;
        Y = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_gap got busy=%b done=%b exp 1/0", busy, done);
            n_fail++;
        end
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i - 1;
                break;
            end
        end
        n_checks++;
        if (lat !== 4 || {B_out, overflow, Z} !== {2'b00, 16'h00FF}) begin
            $display("FAIL b2b_second got lat=%0d res=%h exp 4/000ff",
                     lat, {B_out, overflow, Z});
            n_fail++;
        end
    endtask

    task automatic test_async_reset;
        int dones;
        int lat;
        int bcnt;
        @(negedge clk);
        X = 16'hF000;
        Y = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b1 || Z === 16'h0) begin
            $display("FAIL pre_reset got busy=%b z=%h exp 1/nonzero",
                     busy, Z);
            n_fail++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, B_out, overflow, Z} !== 20'h0) begin
            $display("FAIL async_reset got=%h exp=0",
                     {busy, done, B_out, overflow, Z});
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            $display("FAIL no_done_after_abort got=%0d exp=0", dones);
            n_fail++;
        end
        run_op(16'hF000, 16'h0001, lat, bcnt);
        n_checks++;
        if (lat !== 4 || {B_out, overflow, Z} !== ref_sub(16'hF000, 16'h0001)) begin
            $display("FAIL fresh_after_reset got lat=%0d res=%h exp 4/%h",
                     lat, {B_out, overflow, Z}, ref_sub(16'hF000, 16'h0001));
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_vectors();
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bn_nibble_subtractor.md
Name: bN_nibble_subtractor

Overview:
- Multi-cycle N-bit subtractor computing Z = X - Y as X + ~Y + 1.
- Processes one 4-bit nibble per clock, LSB nibble first, through a single instance of the existing b4_cla_block.
- Sits alongside the combinational adders in the ALU datapath as the area-lean subtract path.
- Uses a start/busy/done handshake.

Parameters:
- N, 16, operand width in bits; must be a multiple of 4 and at least 8. Any other value is a configuration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a subtraction; sampled only when busy=0
- X  input  N  minuend (signed two's complement); captured on the accepting edge
- Y  input  N  subtrahend (signed two's complement); captured on the accepting edge
- busy  output  1  high while a subtraction is in progress
- done  output  1  single-cycle pulse when Z, B_out and overflow become valid
- Z  output  N  difference X - Y modulo 2^N
- B_out  output  1  unsigned borrow: 1 iff X < Y as unsigned values
- overflow  output  1  signed overflow of X - Y

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: FSM in IDLE; busy=0, done=0, Z=0, B_out=0, overflow=0; internal operand registers, nibble counter and carry are cleared.
- States: IDLE and RUN.
- IDLE with start=1 at a rising edge:
  - latch X into A_reg and ~Y into B_reg;
  - set carry=1, set cnt=0, clear the Z register;
  - go to RUN; busy=1 from that edge.
- IDLE with start=0: hold all outputs. Z, B_out and overflow keep the last result.
- RUN, each edge:
  - feed nibble cnt of A_reg and B_reg, plus carry, to b4_cla_block;
  - write the 4-bit sum into Z[4*cnt+3 : 4*cnt];
  - carry takes the block's C_out;
  - cnt increments.
- RUN, edge with cnt = N/4-1 (last nibble):
  - B_out = ~C_out;
  - overflow = block overflow output, which equals (A msb == B_reg msb) && (sum msb != A msb);
  - done=1 for exactly the next cycle; busy=0; go to IDLE.
- Latency: the start edge is edge 0. The result is written on edge N/4, and done is high during the cycle after edge N/4 (4 cycles for N=16).
- Z is partially updated during RUN. It is valid only from the done cycle until the next accepted start.
- start while busy=1 is ignored; the operation in progress and its operands are unaffected. X/Y changes during RUN have no effect.
- Back-to-back: start=1 in the done cycle is accepted, because the FSM is already in IDLE. done falls and busy rises on that edge.
- Reset mid-operation: rst_n low forces IDLE and the reset values immediately, without waiting for clk. No done pulse is produced for the aborted operation.
- cnt width is clog2(N/4). The counter never wraps inside RUN, since the FSM exits at N/4-1.
- No combinational path from any input to any output. All outputs are registered.

Test Plan (N=16):
- Reset, then start with X=16'h0005, Y=16'h0003 → done in cycle 4 after the start edge; Z=16'h0002, B_out=0, overflow=0; busy high for exactly 4 cycles.
- X=16'h0003, Y=16'h0005 → Z=16'hFFFE, B_out=1, overflow=0.
- X=16'h8000, Y=16'h0001 → Z=16'h7FFF, B_out=0, overflow=1. Then X=16'h7FFF, Y=16'hFFFF → Z=16'h8000, B_out=1, overflow=1.
- X=16'h1234, Y=16'h1234 → Z=16'h0000, B_out=0, overflow=0. Also pulse start again 2 cycles into the run with X=16'hFFFF: that start is ignored and Z stays 16'h0000 with a single done pulse.
- Back-to-back: hold start=1 in the done cycle with X=16'h0100, Y=16'h0001 → second done 4 cycles later with Z=16'h00FF; no idle gap between busy periods.
- Assert rst_n=0 asynchronously mid-cycle during cycle 2 of X=16'hF000, Y=16'h0001 → busy, done, Z, B_out and overflow all 0 before the next clk edge; no done after release. A fresh start then yields correct results.
- All scenarios: a self-checking reference compares against X-Y, {X<Y} and signed overflow. The bench reports an error count and finishes with 0.
